// File: rtl/apb_pkg.sv
// Shared types for the APB requester: one-hot FSM encoding and the
// default-width command record used by the bridge side.
package apb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } apb_state_e;

    localparam int APB_PROT_W = 3;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic [APB_PROT_W-1:0] prot;
    } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: counts stalled ACCESS cycles and flags the cycle in
// which the count reaches TIMEOUT. TIMEOUT=0 removes the logic entirely.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] cnt_q;

            always_ff @(posedge pclk or negedge prst) begin
                if (!prst)
                    cnt_q <= '0;
                else if (clear)
                    cnt_q <= '0;
                else if (enable && cnt_q != CW'(TIMEOUT))
                    cnt_q <= cnt_q + 1'b1;
            end

            // Fires in the stalled cycle whose increment would reach TIMEOUT.
            assign expire = enable && (cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_wdog
            logic unused_wdog;
            assign unused_wdog = ^{pclk, prst, clear, enable};
            assign expire      = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: turns valid/ready commands into SETUP/ACCESS transfers,
// supports back-to-back issue and returns a registered one-cycle response.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    input  logic [APB_PROT_W-1:0] cmd_prot,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    output logic [APB_PROT_W-1:0] pprot,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
        logic [STRB_W-1:0]     strb;
        logic [APB_PROT_W-1:0] prot;
    } hold_t;

    apb_state_e state_q, state_d;
    hold_t      hold_q;
    logic       capture, complete, timeout_hit;
    logic       wd_clear, wd_en, expire;

    assign wd_clear = (state_q == SETUP);
    assign wd_en    = (state_q == ACCESS) && !pready;

    apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
        .pclk   (pclk),
        .prst   (prst),
        .clear  (wd_clear),
        .enable (wd_en),
        .expire (expire)
    );

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        capture     = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Reset holds the FSM in IDLE, so ready must be gated here.
                cmd_ready = prst;
                if (cmd_valid) begin
                    capture = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    complete  = 1'b1;
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        capture = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (expire) begin
                    complete    = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            hold_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (capture) begin
                hold_q.write <= cmd_write;
                hold_q.addr  <= cmd_addr;
                hold_q.wdata <= cmd_wdata;
                hold_q.strb  <= {STRB_W{cmd_write}} & cmd_strb;
                hold_q.prot  <= cmd_prot;
            end
            rsp_valid <= complete;
            if (complete) begin
                rsp_rdata   <= (hold_q.write || timeout_hit) ? '0 : prdata;
                rsp_err     <= timeout_hit | pslverr;
                rsp_timeout <= timeout_hit;
            end
        end
    end

    assign psel    = (state_q != IDLE);
    assign penable = (state_q == ACCESS);
    assign pwrite  = hold_q.write;
    assign paddr   = hold_q.addr;
    assign pwdata  = hold_q.wdata;
    assign pstrb   = hold_q.strb;
    assign pprot   = hold_q.prot;

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Parametrised APB (AMBA 3/4) requester. Converts a valid/ready command channel from the CPU/bridge into IDLE->SETUP->ACCESS bus transfers and returns read data and error status on a one-cycle response channel.
- Adds features the first-generation master lacks:
  - configurable address and data widths
  - write strobes and protection attributes
  - back-to-back transfers without returning to IDLE
  - an ACCESS-phase timeout watchdog
- Sits between the system bridge and the APB slave fabric.

Parameters:
- ADDR_W, 32, paddr/cmd_addr width.
- DATA_W, 32, data width; legal values are 8, 16 and 32.
- TIMEOUT, 16, maximum ACCESS cycles allowed without pready; 0 disables the watchdog.

Ports:
- pclk  in  1  APB clock
- prst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  byte strobes (writes only)
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  pslverr or timeout
- rsp_timeout  out  1  completion was due to the watchdog
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W
- pwdata  out  DATA_W
- pstrb  out  DATA_W/8
- pprot  out  3
- prdata  in  DATA_W
- pready, pslverr  in  1

Behaviour:
- Reset: prst is asynchronous, active-low; clock is pclk. While prst is low, the state is IDLE and every output is 0, including cmd_ready.
  - Reset asserted mid-transfer aborts the transfer immediately. No response is issued.
- States (one-hot in the shared package): IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid: capture write/addr/wdata/strb/prot into holding registers and go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0, with paddr/pwrite/pwdata/pstrb/pprot driven from the holding registers.
  - Always go to ACCESS; cmd_valid is ignored here.
- ACCESS:
  - psel=1, penable=1. All address, control and data outputs are held stable until completion.
  - Completion occurs on the first cycle with pready=1, or on the watchdog expiring, whichever comes first.
  - pslverr is sampled only on the completion cycle.
- pstrb is driven as all-zero for reads.
- Response, registered:
  - rsp_valid pulses high for exactly 1 cycle, on the cycle after completion.
  - rsp_rdata = prdata sampled at completion for a read; otherwise 0.
  - rsp_err = pslverr (pready completion), or 1 (timeout).
  - rsp_timeout = 1 only on timeout.
  - rsp_* outputs other than rsp_valid hold their value until the next completion.
- Back-to-back:
  - cmd_ready is also high in an ACCESS cycle where pready=1 and the watchdog has not fired (combinational from pready).
  - If cmd_valid is high in that cycle, capture the new command and go directly to SETUP. psel stays high and penable drops for that SETUP cycle.
  - Otherwise go to IDLE.
  - cmd_ready is 0 in SETUP, and 0 in ACCESS while pready=0.
- Watchdog (TIMEOUT>0):
  - The counter clears on SETUP and increments on each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT and pready is still 0, the transfer completes with a timeout. The next state is IDLE, so psel/penable are 0 on the following cycle. No back-to-back capture happens on a timeout cycle.
  - If pready=1 arrives in the same cycle the count reaches TIMEOUT, pready wins and the transfer is a normal completion.
  - Counter width is $clog2(TIMEOUT+1); the counter saturates and never wraps.
- TIMEOUT=0: the watchdog logic is removed. ACCESS waits indefinitely.
- Zero-wait-state slave: each transfer is exactly 2 cycles (SETUP + ACCESS). Back-to-back throughput is 1 transfer per 2 cycles.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e (IDLE=3'b001, SETUP=3'b010, ACCESS=3'b100)
  - APB_PROT_W=3
  - apb_cmd_t struct (write, addr, wdata, strb, prot), parametrised through package localparams for default widths
- One sub-module: apb_timeout_cnt.
  - Ports: clear, enable, expire, parameter TIMEOUT.
  - Generate-guarded so that expire ties to 0 when TIMEOUT=0.

Test Plan:
- Write, zero wait: cmd write addr=0x0000_0040, wdata=0xDEAD_BEEF, strb=4'hF.
  -> SETUP one cycle with paddr=0x40, pwrite=1; ACCESS one cycle; rsp_valid one cycle later with rsp_err=0, rsp_rdata=0.
- Read, 3 wait states: cmd read addr=0x0000_0100; slave holds pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0x1234_5678.
  -> penable high for 4 cycles, paddr stable throughout; rsp_rdata=0x1234_5678, rsp_err=0.
- Slave error: write addr=0x0000_0200; slave returns pready=1, pslverr=1.
  -> rsp_err=1, rsp_timeout=0; state returns to IDLE.
- Timeout with TIMEOUT=4: slave never asserts pready.
  -> penable high for exactly 4 cycles, then psel=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  -> Repeat with pready=1 on the 4th ACCESS cycle: normal completion, rsp_timeout=0.
- Back-to-back: cmd_valid held high with 3 queued commands (write 0x10, read 0x14, write 0x18) and zero-wait slave.
  -> psel high continuously for 6 cycles with penable toggling 0,1,0,1,0,1; exactly 3 rsp_valid pulses, in order.
- Reset mid-ACCESS: prst driven low while penable=1.
  -> psel, penable, rsp_valid and cmd_ready read 0 asynchronously; no rsp_valid after release; next command proceeds normally from IDLE.
